// File: rtl/lcd_pkg.sv
// Shared LCD interface definitions: FSM state encodings and default bus timing
// (50 MHz clock) used by the read and write engines.
package lcd_pkg;

   localparam int DEF_T_SETUP   = 2;
   localparam int DEF_T_E_HIGH  = 12;
   localparam int DEF_T_SAMPLE  = 10;
   localparam int DEF_T_HOLD    = 1;
   localparam int DEF_T_GAP     = 50;
   localparam int DEF_MAX_POLLS = 1000;

   localparam int CNT_W  = 8;
   localparam int POLL_W = 10;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SETUP_H = 4'd1,
      ST_E_H     = 4'd2,
      ST_HOLD_H  = 4'd3,
      ST_GAP     = 4'd4,
      ST_SETUP_L = 4'd5,
      ST_E_L     = 4'd6,
      ST_HOLD_L  = 4'd7,
      ST_DONE    = 4'd8,
      ST_RETRY   = 4'd9
   } rd_state_e;

   typedef enum logic [1:0] {
      NP_IDLE  = 2'd0,
      NP_SETUP = 2'd1,
      NP_E     = 2'd2,
      NP_HOLD  = 2'd3
   } nib_phase_e;

   // Poll counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [POLL_W-1:0] sat_inc(input logic [POLL_W-1:0] v);
      return (v == {POLL_W{1'b1}}) ? v : v + POLL_W'(1);
   endfunction

endpackage

// File: rtl/lcd_nibble_reader.sv
// One-nibble read strobe: SETUP -> E high -> HOLD, sampling the bus at a fixed
// offset inside the E-high window.
module lcd_nibble_reader #(
   parameter int T_SETUP  = lcd_pkg::DEF_T_SETUP,
   parameter int T_E_HIGH = lcd_pkg::DEF_T_E_HIGH,
   parameter int T_SAMPLE = lcd_pkg::DEF_T_SAMPLE,
   parameter int T_HOLD   = lcd_pkg::DEF_T_HOLD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] sf_d_in,
   output logic       lcd_e,
   output logic       phase_end,
   output logic [3:0] nibble
);
   import lcd_pkg::*;

   nib_phase_e       phase_r, phase_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             e_r;
   logic [3:0]       nibble_r;
   logic             phase_end_s;

   // last cycle of the current phase
   always_comb begin
      phase_end_s = 1'b0;
      case (phase_r)
         NP_SETUP: phase_end_s = (cnt_r == CNT_W'(T_SETUP - 1));
         NP_E:     phase_end_s = (cnt_r == CNT_W'(T_E_HIGH - 1));
         NP_HOLD:  phase_end_s = (cnt_r == CNT_W'(T_HOLD - 1));
         default:  phase_end_s = 1'b0;
      endcase
   end

   // phase sequencing
   always_comb begin
      phase_nxt_s = phase_r;
      case (phase_r)
         NP_IDLE:  phase_nxt_s = start       ? NP_SETUP : NP_IDLE;
         NP_SETUP: phase_nxt_s = phase_end_s ? NP_E     : NP_SETUP;
         NP_E:     phase_nxt_s = phase_end_s ? NP_HOLD  : NP_E;
         NP_HOLD:  phase_nxt_s = phase_end_s ? NP_IDLE  : NP_HOLD;
         default:  phase_nxt_s = NP_IDLE;
      endcase
   end

   // phase/counter registers; E is registered from the next phase so it tracks NP_E exactly
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_r  <= NP_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         e_r      <= 1'b0;
         nibble_r <= 4'h0;
      end else begin
         phase_r <= phase_nxt_s;
         if ((phase_nxt_s != phase_r) || (phase_r == NP_IDLE)) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         e_r <= (phase_nxt_s == NP_E);
         if ((phase_r == NP_E) && (cnt_r == CNT_W'(T_SAMPLE))) begin
            nibble_r <= sf_d_in;
         end else begin
            nibble_r <= nibble_r;
         end
      end
   end

   assign lcd_e     = e_r;
   assign phase_end = phase_end_s;
   assign nibble    = nibble_r;

endmodule

// File: rtl/lcd_read_fsm.sv
// 4-bit LCD read engine: two nibble strobes per byte, with optional busy-flag
// polling that repeats the read until BF clears or the poll limit is hit.
module lcd_read_fsm #(
   parameter int T_SETUP   = lcd_pkg::DEF_T_SETUP,
   parameter int T_E_HIGH  = lcd_pkg::DEF_T_E_HIGH,
   parameter int T_SAMPLE  = lcd_pkg::DEF_T_SAMPLE,
   parameter int T_HOLD    = lcd_pkg::DEF_T_HOLD,
   parameter int T_GAP     = lcd_pkg::DEF_T_GAP,
   parameter int MAX_POLLS = lcd_pkg::DEF_MAX_POLLS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rs,
   input  logic       poll_busy,
   input  logic [3:0] SF_D_in,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       timeout
);
   import lcd_pkg::*;

   rd_state_e         state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [POLL_W-1:0] poll_cnt_r, poll_inc_s;
   logic              rs_l_r, poll_l_r;
   logic [3:0]        hi_r;
   logic              nib_start_s, nib_end_s, gap_end_s, bf_hit_s, retry_s, done_s;
   logic [3:0]        nib_val_s;
   logic              rs_s, rw_s, busy_s, rd_valid_s, timeout_s;
   logic [7:0]        rd_data_s;
   logic              rs_r, rw_r, busy_r, rd_valid_r, timeout_r;
   logic [7:0]        rd_data_r;

   lcd_nibble_reader #(
      .T_SETUP  (T_SETUP),
      .T_E_HIGH (T_E_HIGH),
      .T_SAMPLE (T_SAMPLE),
      .T_HOLD   (T_HOLD)
   ) u_nib (
      .clk       (clk),
      .reset     (reset),
      .start     (nib_start_s),
      .sf_d_in   (SF_D_in),
      .lcd_e     (LCD_E),
      .phase_end (nib_end_s),
      .nibble    (nib_val_s)
   );

   assign gap_end_s  = (cnt_r == CNT_W'(T_GAP - 1));
   assign poll_inc_s = sat_inc(poll_cnt_r);
   assign bf_hit_s   = poll_l_r && !rs_l_r && hi_r[3];
   assign retry_s    = bf_hit_s && (32'(poll_inc_s) < 32'(MAX_POLLS));
   assign done_s     = (state_r == ST_DONE) && !retry_s;

   // state, timing counter, latched request and high nibble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         poll_cnt_r <= {POLL_W{1'b0}};
         rs_l_r     <= 1'b0;
         poll_l_r   <= 1'b0;
         hi_r       <= 4'h0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if ((state_r == ST_IDLE) && start) begin
            rs_l_r     <= rs;
            poll_l_r   <= poll_busy;
            poll_cnt_r <= {POLL_W{1'b0}};
         end else if (state_r == ST_DONE) begin
            poll_cnt_r <= poll_inc_s;
         end else begin
            poll_cnt_r <= poll_cnt_r;
         end
         if ((state_r == ST_HOLD_H) && nib_end_s) begin
            hi_r <= nib_val_s;
         end else begin
            hi_r <= hi_r;
         end
      end
   end

   // next state; each nibble strobe is launched on entry to its SETUP state
   always_comb begin
      state_nxt_s = state_r;
      nib_start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = start ? ST_SETUP_H : ST_IDLE;
            nib_start_s = start;
         end
         ST_SETUP_H: state_nxt_s = nib_end_s ? ST_E_H    : ST_SETUP_H;
         ST_E_H:     state_nxt_s = nib_end_s ? ST_HOLD_H : ST_E_H;
         ST_HOLD_H:  state_nxt_s = nib_end_s ? ST_GAP    : ST_HOLD_H;
         ST_GAP: begin
            state_nxt_s = gap_end_s ? ST_SETUP_L : ST_GAP;
            nib_start_s = gap_end_s;
         end
         ST_SETUP_L: state_nxt_s = nib_end_s ? ST_E_L    : ST_SETUP_L;
         ST_E_L:     state_nxt_s = nib_end_s ? ST_HOLD_L : ST_E_L;
         ST_HOLD_L:  state_nxt_s = nib_end_s ? ST_DONE   : ST_HOLD_L;
         ST_DONE:    state_nxt_s = retry_s   ? ST_RETRY  : ST_IDLE;
         ST_RETRY: begin
            state_nxt_s = gap_end_s ? ST_SETUP_H : ST_RETRY;
            nib_start_s = gap_end_s;
         end
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // output values for the next cycle; the result leaves DONE so busy covers the rd_valid cycle
   always_comb begin
      rw_s       = (state_nxt_s != ST_IDLE);
      rs_s       = rw_s && ((state_r == ST_IDLE) ? rs : rs_l_r);
      busy_s     = rw_s || (state_r == ST_DONE);
      rd_valid_s = done_s;
      timeout_s  = done_s && bf_hit_s;
      rd_data_s  = done_s ? {hi_r, nib_val_s} : rd_data_r;
   end

   // output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs_r       <= 1'b0;
         rw_r       <= 1'b0;
         busy_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         timeout_r  <= 1'b0;
         rd_data_r  <= 8'h00;
      end else begin
         rs_r       <= rs_s;
         rw_r       <= rw_s;
         busy_r     <= busy_s;
         rd_valid_r <= rd_valid_s;
         timeout_r  <= timeout_s;
         rd_data_r  <= rd_data_s;
      end
   end

   assign LCD_RS   = rs_r;
   assign LCD_RW   = rw_r;
   assign busy     = busy_r;
   assign rd_valid = rd_valid_r;
   assign timeout  = timeout_r;
   assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Directed bench for lcd_read_fsm: an LCD bus model returns scripted bytes,
// valid only in the sampling cycle of each E strobe.
module tb_lcd_read_fsm;

   localparam int TE = 12;
   localparam int TS = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, rs, poll_busy, start2;
   logic [3:0] sf_d_in, sf_d2;
   logic       lcd_rs, lcd_rw, lcd_e, rd_valid, busy, timeout;
   logic       lcd_rs2, lcd_rw2, lcd_e2, rd_valid2, busy2, timeout2;
   logic [7:0] rd_data, rd_data2;

   lcd_read_fsm u_dut (
      .clk(clk), .reset(reset), .start(start), .rs(rs), .poll_busy(poll_busy),
      .SF_D_in(sf_d_in), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .timeout(timeout)
   );

   lcd_read_fsm #(.MAX_POLLS(4)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .rs(1'b0), .poll_busy(1'b1),
      .SF_D_in(sf_d2), .LCD_RS(lcd_rs2), .LCD_RW(lcd_rw2), .LCD_E(lcd_e2),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .timeout(timeout2)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // bus model for u_dut
   logic [7:0] bytes_q [0:7];
   int   pulse_cnt = 0, pulse_base = 0, e_idx = 0;
   int   width_err = 0, rw_err = 0, valid_cnt = 0, to_cnt = 0;
   logic prev_e = 1'b0;

   always @(negedge clk) begin : model1
      int         n, rd_i;
      logic [7:0] b;
      logic [3:0] good;
      if (lcd_e && !lcd_rw) rw_err++;
      if (prev_e && !lcd_e) begin
         if (e_idx != TE) width_err++;
         pulse_cnt++;
         e_idx = 0;
      end
      n    = pulse_cnt - pulse_base;
      rd_i = n / 2;
      b    = (rd_i >= 0 && rd_i < 8) ? bytes_q[rd_i] : 8'h00;
      good = (n % 2 == 0) ? b[7:4] : b[3:0];
      if (lcd_e) begin
         sf_d_in = (e_idx == TS) ? good : ~good;
         e_idx++;
      end else begin
         sf_d_in = ~good;
      end
      prev_e = lcd_e;
      if (rd_valid) valid_cnt++;
      if (timeout) to_cnt++;
   end

   // bus model for u_dut2: status byte 0x80 forever
   int   pulse2 = 0;
   logic prev_e2 = 1'b0;
   always @(negedge clk) begin : model2
      if (prev_e2 && !lcd_e2) pulse2++;
      sf_d2   = pulse2[0] ? 4'h0 : 4'h8;
      prev_e2 = lcd_e2;
   end

   task automatic start_read(input logic r, input logic p);
      @(negedge clk);
      rs = r; poll_busy = p; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!rd_valid && lat < 3000) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("valid_seen", {31'd0, rd_valid}, 32'd1);
   endtask

   int lat, w0, v0, guard;

   initial begin
      reset = 1'b0; start = 1'b0; rs = 1'b0; poll_busy = 1'b0; start2 = 1'b0;
      for (int i = 0; i < 8; i++) bytes_q[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_e",     {31'd0, lcd_e},    32'd0);
      chk("rst_rw",    {31'd0, lcd_rw},   32'd0);
      chk("rst_rs",    {31'd0, lcd_rs},   32'd0);
      chk("rst_busy",  {31'd0, busy},     32'd0);
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_to",    {31'd0, timeout},  32'd0);
      chk("rst_data",  {24'd0, rd_data},  32'h00);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: data RAM read 0xA5
      bytes_q[0] = 8'hA5; pulse_base = pulse_cnt; w0 = width_err; v0 = valid_cnt;
      start_read(1'b1, 1'b0);
      chk("busy_start", {31'd0, busy},   32'd1);
      chk("rw_start",   {31'd0, lcd_rw}, 32'd1);
      chk("rs_start",   {31'd0, lcd_rs}, 32'd1);
      wait_valid(lat);
      chk("latency",    lat,                32'd81);
      chk("data_a5",    {24'd0, rd_data},   32'hA5);
      chk("to_a5",      {31'd0, timeout},   32'd0);
      chk("busy_valid", {31'd0, busy},      32'd1);
      @(posedge clk); #1;
      chk("valid_1clk", {31'd0, rd_valid},  32'd0);
      chk("busy_end",   {31'd0, busy},      32'd0);
      chk("pulses_a5",  pulse_cnt - pulse_base, 32'd2);
      chk("width_a5",   width_err - w0,     32'd0);
      chk("valids_a5",  valid_cnt - v0,     32'd1);

      // 2: busy poll, BF set three times
      bytes_q[0] = 8'h8C; bytes_q[1] = 8'h8C; bytes_q[2] = 8'h8C; bytes_q[3] = 8'h0C;
      repeat (3) @(negedge clk);
      pulse_base = pulse_cnt; w0 = width_err; v0 = valid_cnt;
      start_read(1'b0, 1'b1);
      wait_valid(lat);
      chk("data_poll",  {24'd0, rd_data},   32'h0C);
      chk("to_poll",    {31'd0, timeout},   32'd0);
      @(posedge clk); #1;
      chk("pulses_poll", pulse_cnt - pulse_base, 32'd8);
      chk("width_poll",  width_err - w0,    32'd0);
      chk("valids_poll", valid_cnt - v0,    32'd1);

      // 6: only the sampling cycle carries the real value
      bytes_q[0] = 8'h3C;
      repeat (3) @(negedge clk);
      pulse_base = pulse_cnt;
      start_read(1'b1, 1'b0);
      wait_valid(lat);
      chk("sample_pt", {24'd0, rd_data}, 32'h3C);
      repeat (5) @(posedge clk); #1;
      chk("data_hold", {24'd0, rd_data}, 32'h3C);

      // 4: second start during E_H is ignored
      bytes_q[0] = 8'h5A;
      repeat (3) @(negedge clk);
      pulse_base = pulse_cnt; v0 = valid_cnt;
      start_read(1'b1, 1'b0);
      guard = 0;
      while (!lcd_e && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("e_rise_seen", {31'd0, lcd_e}, 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_valid(lat);
      chk("data_5a", {24'd0, rd_data}, 32'h5A);
      repeat (200) @(posedge clk); #1;
      chk("one_valid", valid_cnt - v0, 32'd1);
      chk("no_restart", {31'd0, busy}, 32'd0);

      // 5: asynchronous reset during E_L, then a clean read
      bytes_q[0] = 8'hFF;
      pulse_base = pulse_cnt;
      start_read(1'b1, 1'b0);
      guard = 0;
      while (!((pulse_cnt - pulse_base) == 1 && lcd_e) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("el_seen", {31'd0, lcd_e}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_e",    {31'd0, lcd_e},  32'd0);
      chk("arst_rw",   {31'd0, lcd_rw}, 32'd0);
      chk("arst_rs",   {31'd0, lcd_rs}, 32'd0);
      chk("arst_busy", {31'd0, busy},   32'd0);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      bytes_q[0] = 8'h69; pulse_base = pulse_cnt;
      start_read(1'b1, 1'b0);
      wait_valid(lat);
      chk("lat_after_rst",  lat,              32'd81);
      chk("data_after_rst", {24'd0, rd_data}, 32'h69);

      // 3: poll limit of 4 with BF stuck
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      guard = 0;
      while (!rd_valid2 && guard < 2000) begin
         @(posedge clk);
         #1 guard++;
      end
      chk("to_valid", {31'd0, rd_valid2}, 32'd1);
      chk("to_flag",  {31'd0, timeout2},  32'd1);
      chk("to_data",  {24'd0, rd_data2},  32'h80);
      @(posedge clk); #1;
      chk("to_pulses", pulse2, 32'd8);
      chk("to_1clk",   {31'd0, timeout2}, 32'd0);

      chk("rw_in_e", rw_err, 32'd0);
      chk("no_to_1", to_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
